gpio_apb_seq: RTL

GPIO_APB_SEQ -- requirements
Module: gpio_apb_seq

---
 rtl/gpio_apb_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/gpio_apb_seq.sv
// APB3 master sequencer for a GPIO slave: configures it at start-up, then services
// interrupt clears, output-register writes and periodic input polls one transfer at a time.
module gpio_apb_seq #(
  parameter int          POLL_DIV = 1000,
  parameter logic [31:0] CFG_VAL  = 32'h0000_0005
) (
  input  logic        PCLK,
  input  logic        PRESET,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [7:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  input  logic [3:0]  GPIO_INT,
  input  logic        out_req,
  input  logic [3:0]  out_data,
  output logic        out_ack,
  output logic [3:0]  in_data,
  output logic        in_valid,
  output logic        init_done,
  output logic        err
);

  typedef enum logic [1:0] {INIT, IDLE, SETUP, ACCESS} state_t;
  typedef enum logic [1:0] {XFER_CFG, XFER_INT, XFER_OUT, XFER_POLL} xfer_t;

  localparam logic [15:0] POLL_MAX = 16'(POLL_DIV - 1);

  state_t      r_state;
  xfer_t       r_xfer;
  logic [1:0]  r_cfgIdx;
  logic [15:0] r_pollCnt;
  logic        r_pollPend;
  logic        r_psel;
  logic        r_penable;
  logic        r_pwrite;
  logic [7:0]  r_paddr;
  logic [31:0] r_pwdata;
  logic        r_outAck;
  logic        r_inValid;
  logic [3:0]  r_inData;
  logic        r_initDone;
  logic        r_err;

  logic w_pollWrap;
  logic w_pollDone;
  logic w_unusedPrdata;

  assign w_pollWrap     = r_initDone && (r_pollCnt == POLL_MAX);
  assign w_pollDone     = (r_state == ACCESS) && PREADY && (r_xfer == XFER_POLL);
  assign w_unusedPrdata = ^PRDATA[31:4];

  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign out_ack   = r_outAck;
  assign in_data   = r_inData;
  assign in_valid  = r_inValid;
  assign init_done = r_initDone;
  assign err       = r_err;

  // A wrap landing on the same edge as a poll completion re-arms the poll for the new period.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_pollCnt  <= '0;
      r_pollPend <= 1'b0;
    end else if (r_initDone) begin
      if (w_pollWrap) begin
        r_pollCnt  <= '0;
        r_pollPend <= 1'b1;
      end else begin
        r_pollCnt <= r_pollCnt + 16'd1;
        if (w_pollDone) r_pollPend <= 1'b0;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state    <= INIT;
      r_xfer     <= XFER_CFG;
      r_cfgIdx   <= 2'd0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= 8'h00;
      r_pwdata   <= 32'h0;
      r_outAck   <= 1'b0;
      r_inValid  <= 1'b0;
      r_inData   <= 4'h0;
      r_initDone <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_outAck  <= 1'b0;
      r_inValid <= 1'b0;
      case (r_state)
        INIT: begin
          r_psel   <= 1'b1;
          r_pwrite <= 1'b1;
          r_paddr  <= {4'b0, r_cfgIdx, 2'b00};
          r_pwdata <= CFG_VAL;
          r_xfer   <= XFER_CFG;
          r_state  <= SETUP;
        end
        // The ack cycle still sees out_req held high, so it must not start a second write.
        IDLE: begin
          if (GPIO_INT != 4'h0) begin
            r_psel   <= 1'b1;
            r_pwrite <= 1'b1;
            r_paddr  <= 8'h80;
            r_pwdata <= {28'b0, GPIO_INT};
            r_xfer   <= XFER_INT;
            r_state  <= SETUP;
          end else if (out_req && !r_outAck) begin
            r_psel   <= 1'b1;
            r_pwrite <= 1'b1;
            r_paddr  <= 8'hA0;
            r_pwdata <= {28'b0, out_data};
            r_xfer   <= XFER_OUT;
            r_state  <= SETUP;
          end else if (r_pollPend) begin
            r_psel   <= 1'b1;
            r_pwrite <= 1'b0;
            r_paddr  <= 8'h90;
            r_pwdata <= 32'h0;
            r_xfer   <= XFER_POLL;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            if (PSLVERR) r_err <= 1'b1;
            case (r_xfer)
              XFER_CFG: begin
                r_cfgIdx <= r_cfgIdx + 2'd1;
                if (r_cfgIdx == 2'd3) begin
                  r_initDone <= 1'b1;
                  r_state    <= IDLE;
                end else begin
                  r_state <= INIT;
                end
              end
              XFER_OUT: begin
                r_outAck <= 1'b1;
                r_state  <= IDLE;
              end
              XFER_POLL: begin
                r_inData  <= PRDATA[3:0];
                r_inValid <= 1'b1;
                r_state   <= IDLE;
              end
              default: r_state <= IDLE;
            endcase
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

endmodule
